// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues req/ack fetches at the current PC, holds the
// returned word for decode and pulses pc_adv once per captured instruction.
module ifetch_unit #(
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               flush,
  input  logic [15:0]        pc_in,
  output logic               pc_adv,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [15:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t              state_q, state_d;
  logic [15:0]         addr_q, addr_d;
  logic [INSTR_W-1:0]  out_q, out_d;
  logic [15:0]         ipc_q, ipc_d;
  logic                adv_q, adv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                waiting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      out_q   <= '0;
      ipc_q   <= '0;
      adv_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
      adv_q   <= adv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    adv_d   = 1'b0;
    waiting = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en && !flush) begin
          state_d = REQ;
          addr_d  = pc_in;
        end
      end
      REQ: begin
        if (imem_ack) begin
          // A flush coinciding with the ack still drops the word.
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            out_d   = imem_rdata;
            ipc_d   = addr_q;
            adv_d   = 1'b1;
          end
        end else if (flush) begin
          state_d = DISCARD;
        end else begin
          waiting = 1'b1;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = IDLE;
        else          waiting = 1'b1;
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (instr_ready) begin
          if (fetch_en) begin
            state_d = REQ;
            addr_d  = pc_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Wait counter saturates so a stalled memory cannot wrap it.
    cnt_d = '0;
    err_d = err_q;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      if (cnt_q >= CNT_MAX - CNT_ONE) err_d = 1'b1;
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = addr_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;
  assign pc_adv      = adv_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: vector table, directed corner sequences and a
// randomized run against a flag-based reference model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc_in = '0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        pc_adv, imem_req, instr_valid, fetch_err;
  logic [15:0] imem_addr, instr_out, instr_pc;

  int errors = 0;
  int checks = 0;
  int adv_cnt = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.INSTR_W(16), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .pc_in      (pc_in),
    .pc_adv     (pc_adv),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_err  (fetch_err)
  );

  always @(negedge clk) if (pc_adv) adv_cnt++;

  typedef struct {
    logic        en, fl;
    logic [15:0] pc;
    logic        ack;
    logic [15:0] rd;
    logic        rdy;
    logic        req, adv, vld;
    logic [15:0] addr, out, ipc;
  } vec_t;

  vec_t tbl[12];

  // reference model state
  logic        m_pend, m_drop, m_held, m_adv, m_err;
  logic [15:0] m_addr, m_out, m_ipc;
  int          m_wcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fl, input logic [15:0] pc,
                       input logic ack, input logic [15:0] rd, input logic rdy);
    fetch_en = en; flush = fl; pc_in = pc;
    imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {12'h0, imem_req, pc_adv, instr_valid, fetch_err, imem_addr, instr_out, instr_pc};
  endfunction

  task automatic model_reset;
    m_pend = 0; m_drop = 0; m_held = 0; m_adv = 0; m_err = 0;
    m_addr = 0; m_out = 0; m_ipc = 0; m_wcnt = 0;
  endtask

  task automatic model_step(input logic en, input logic fl, input logic [15:0] pc,
                            input logic ack, input logic [15:0] rd, input logic rdy);
    logic adv_n;
    adv_n = 1'b0;
    if (m_pend && !ack && !(fl && !m_drop)) begin
      m_wcnt++;
      if (m_wcnt >= 4) m_err = 1'b1;
    end else begin
      m_wcnt = 0;
    end
    if (!m_pend && !m_held) begin
      if (en && !fl) begin m_pend = 1; m_drop = 0; m_addr = pc; end
    end else if (m_pend && !m_drop) begin
      if (ack) begin
        if (!fl) begin m_out = rd; m_ipc = m_addr; adv_n = 1; m_held = 1; end
        m_pend = 0;
      end else if (fl) begin
        m_drop = 1;
      end
    end else if (m_pend) begin
      if (ack) begin m_pend = 0; m_drop = 0; end
    end else begin
      if (fl) m_held = 0;
      else if (rdy) begin
        m_held = 0;
        if (en) begin m_pend = 1; m_addr = pc; end
      end
    end
    m_adv = adv_n;
  endtask

  initial begin
    //        en fl  pc       ack rd       rdy  req adv vld addr     out      ipc
    tbl[0]  = '{1, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 0, 16'h0000, 1, 16'hA5A5, 0,   1, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{1, 0, 16'h0001, 0, 16'h0000, 1,   0, 1, 1, 16'h0000, 16'hA5A5, 16'h0000};
    tbl[3]  = '{0, 0, 16'h0001, 0, 16'h0000, 0,   1, 0, 0, 16'h0001, 16'hA5A5, 16'h0000};
    tbl[4]  = '{0, 0, 16'h0010, 0, 16'h0000, 0,   1, 0, 0, 16'h0001, 16'hA5A5, 16'h0000};
    tbl[5]  = '{0, 0, 16'h0010, 1, 16'h1234, 0,   1, 0, 0, 16'h0001, 16'hA5A5, 16'h0000};
    tbl[6]  = '{0, 0, 16'h0010, 0, 16'h0000, 1,   0, 1, 1, 16'h0001, 16'h1234, 16'h0001};
    tbl[7]  = '{1, 1, 16'h0040, 0, 16'h0000, 0,   0, 0, 0, 16'h0001, 16'h1234, 16'h0001};
    tbl[8]  = '{1, 0, 16'h0040, 0, 16'h0000, 0,   0, 0, 0, 16'h0001, 16'h1234, 16'h0001};
    tbl[9]  = '{0, 1, 16'h0040, 1, 16'hDEAD, 0,   1, 0, 0, 16'h0040, 16'h1234, 16'h0001};
    tbl[10] = '{0, 0, 16'h0040, 0, 16'h0000, 0,   0, 0, 0, 16'h0040, 16'h1234, 16'h0001};
    tbl[11] = '{0, 0, 16'h0040, 0, 16'h0000, 0,   0, 0, 0, 16'h0040, 16'h1234, 16'h0001};

    #3;
    chk("reset_outputs", outs(), 64'h0);
    #9 rst_n = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec[%0d]", i), outs(),
          {12'h0, tbl[i].req, tbl[i].adv, tbl[i].vld, 1'b0, tbl[i].addr, tbl[i].out, tbl[i].ipc});
      drive(tbl[i].en, tbl[i].fl, tbl[i].pc, tbl[i].ack, tbl[i].rd, tbl[i].rdy);
      tick;
    end

    // delayed ack: address held through every waiting cycle
    adv_cnt = 0;
    drive(1, 0, 16'h0010, 0, 0, 0); tick;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 16'h0010);
      drive(0, 0, 16'h0013, 0, 0, 0); tick;
    end
    chk("ack_addr", imem_addr, 16'h0010);
    drive(0, 0, 16'h0013, 1, 16'hBEEF, 0); tick;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out", instr_out, 16'hBEEF);
      chk("hold_ipc", instr_pc, 16'h0010);
      chk("hold_req", imem_req, 0);
      chk("hold_vld", instr_valid, 1);
      drive(1, 0, 16'h0011, 0, 0, 0); tick;
    end
    chk("adv_once", adv_cnt, 1);
    drive(1, 0, 16'h0011, 0, 0, 1); tick;
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, 16'h0011);

    // flush while waiting -> discard
    drive(1, 0, 16'h0020, 1, 16'h1111, 0); tick;
    drive(1, 0, 16'h0020, 0, 0, 1); tick;
    adv_cnt = 0;
    chk("req20_addr", imem_addr, 16'h0020);
    drive(0, 1, 16'h0040, 0, 0, 0); tick;
    chk("disc_req", imem_req, 1);
    chk("disc_addr", imem_addr, 16'h0020);
    chk("disc_vld", instr_valid, 0);
    drive(1, 1, 16'h0040, 0, 0, 0); tick;
    chk("disc_addr2", imem_addr, 16'h0020);
    drive(1, 0, 16'h0040, 1, 16'hDEAD, 0); tick;
    chk("disc_drop_vld", instr_valid, 0);
    chk("disc_drop_req", imem_req, 0);
    chk("disc_drop_out", instr_out, 16'h1111);
    drive(1, 0, 16'h0040, 0, 0, 0); tick;
    chk("new_req", imem_req, 1);
    chk("new_addr", imem_addr, 16'h0040);
    chk("disc_no_adv", adv_cnt, 0);

    // flush in HOLD wins over ready
    drive(1, 0, 16'h0040, 1, 16'h4444, 0); tick;
    chk("h_vld", instr_valid, 1);
    chk("h_out", instr_out, 16'h4444);
    drive(1, 1, 16'h0080, 0, 0, 1); tick;
    chk("flh_vld", instr_valid, 0);
    chk("flh_req", imem_req, 0);
    drive(1, 0, 16'h0080, 0, 0, 0); tick;
    chk("flh_addr", imem_addr, 16'h0080);
    chk("flh_adv_cnt", adv_cnt, 1);

    // timeout with TIMEOUT=4
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 16'h0080, 0, 0, 0); tick;
      chk($sformatf("err_after_%0d", i), fetch_err, (i >= 4));
    end
    drive(0, 0, 16'h0080, 1, 16'h5555, 0); tick;
    chk("err_sticky", fetch_err, 1);
    chk("to_out", instr_out, 16'h5555);
    drive(1, 0, 16'h0090, 0, 0, 1); tick;
    chk("to_next_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 64'h0);

    // randomized run against the model
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    tick;
    for (int c = 0; c < 400; c++) begin
      logic        en, fl, ack, rdy;
      logic [15:0] pc, rd;
      chk($sformatf("rand[%0d]", c), outs(),
          {12'h0, m_pend, m_adv, m_held, m_err, m_addr, m_out, m_ipc});
      en  = ($urandom_range(3) != 0);
      fl  = ($urandom_range(7) == 0);
      ack = ($urandom_range(2) == 0);
      rdy = 1'($urandom_range(1));
      pc  = 16'($urandom);
      rd  = 16'($urandom);
      drive(en, fl, pc, ack, rd, rdy);
      model_step(en, fl, pc, ack, rd, rdy);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
